// File: rtl/lag_meter.sv
// lag_meter: end-to-end display latency meter. Requests a one-frame flash on a
// VSync edge, times the photo-sensor response in microseconds and keeps
// last/min/max/count statistics for the on-screen readout.
module lag_meter #(
  parameter int unsigned US_DIV            = 50,
  parameter int unsigned TIMEOUT_US        = 200000,
  parameter int unsigned DEBOUNCE          = 16,
  parameter bit          SENSOR_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vsync,
  input  logic        arm,
  input  logic        clear,
  input  logic        sensor_in,
  output logic        flash,
  output logic        busy,
  output logic        result_valid,
  output logic        timeout,
  output logic [17:0] last_us,
  output logic [17:0] min_us,
  output logic [17:0] max_us,
  output logic [7:0]  count
);

  localparam int unsigned PW = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE + 1);

  localparam logic [PW-1:0] PresLast   = PW'(US_DIV - 1);
  localparam logic [DW-1:0] DebLast    = DW'(DEBOUNCE - 1);
  localparam logic [17:0]   TimeoutVal = 18'(TIMEOUT_US);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWaitVs   = 3'd1;
  localparam logic [2:0] StMeasure  = 3'd2;
  localparam logic [2:0] StReport   = 3'd3;
  localparam logic [2:0] StCooldown = 3'd4;

  logic          sync1_q, sync2_q;
  logic          filt_q;
  logic [DW-1:0] deb_cnt_q;
  logic          vs_prev_q;
  logic          vs_rise;
  logic          sens_norm;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] pres_q, pres_d;
  logic [17:0]   us_q, us_d;
  logic          flash_q, flash_d;
  logic          cd_q, cd_d;
  logic          timeout_q, timeout_d;

  logic [17:0]   last_q, min_q, max_q;
  logic [7:0]    count_q;

  // Normalise to active-high before synchronising; with a constant this is just an inverter.
  assign sens_norm = sensor_in ^ SENSOR_ACTIVE_LOW;
  assign vs_rise   = vsync & ~vs_prev_q;

  // Two-flop synchronizer and registered vsync for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      sync1_q   <= sens_norm;
      sync2_q   <= sync1_q;
      vs_prev_q <= vsync;
    end
  end

  // Debouncer: follow the synchronized level only after DEBOUNCE consecutive differing cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q    <= 1'b0;
      deb_cnt_q <= '0;
    end else if (sync2_q != filt_q) begin
      if (deb_cnt_q == DebLast) begin
        filt_q    <= sync2_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
    end else begin
      deb_cnt_q <= '0;
    end
  end

  // Measurement FSM next-state, prescaler and microsecond counter.
  always_comb begin
    state_d   = state_q;
    pres_d    = pres_q;
    us_d      = us_q;
    flash_d   = flash_q;
    cd_d      = cd_q;
    timeout_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (arm) state_d = StWaitVs;
      end
      StWaitVs: begin
        if (!arm) begin
          state_d = StIdle;
        end else if (vs_rise && !filt_q) begin
          state_d = StMeasure;
          // The start cycle itself is prescaler count 0, so cycle 1 already sits at 1.
          pres_d  = PW'(1);
          us_d    = '0;
          flash_d = 1'b1;
        end
      end
      StMeasure: begin
        if (!arm) begin
          state_d = StIdle;
          flash_d = 1'b0;
        end else if (filt_q) begin
          // Counters freeze here so REPORT sees the value at the detection cycle.
          state_d = StReport;
          flash_d = 1'b0;
        end else if (us_q == TimeoutVal) begin
          state_d   = StCooldown;
          flash_d   = 1'b0;
          timeout_d = 1'b1;
          cd_d      = 1'b0;
        end else begin
          if (vs_rise) flash_d = 1'b0;
          if (pres_q == PresLast) begin
            pres_d = '0;
            us_d   = us_q + 18'd1;
          end else begin
            pres_d = pres_q + 1'b1;
          end
        end
      end
      StReport: begin
        cd_d    = 1'b0;
        state_d = arm ? StCooldown : StIdle;
      end
      StCooldown: begin
        if (!arm) begin
          state_d = StIdle;
        end else if (filt_q) begin
          // Sensor still lit: restart the two-edge wait once it goes dark.
          cd_d = 1'b0;
        end else if (vs_rise) begin
          if (cd_q) state_d = StWaitVs;
          else      cd_d    = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        flash_d = 1'b0;
      end
    endcase
  end

  // FSM and counter state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      pres_q    <= '0;
      us_q      <= '0;
      flash_q   <= 1'b0;
      cd_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pres_q    <= pres_d;
      us_q      <= us_d;
      flash_q   <= flash_d;
      cd_q      <= cd_d;
      timeout_q <= timeout_d;
    end
  end

  // Result and statistics; clear overrides a coincident REPORT for min/max/count only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q  <= '0;
      min_q   <= 18'h3FFFF;
      max_q   <= '0;
      count_q <= '0;
    end else begin
      if (state_q == StReport) last_q <= us_q;
      if (clear) begin
        min_q   <= 18'h3FFFF;
        max_q   <= '0;
        count_q <= '0;
      end else if (state_q == StReport) begin
        if (us_q < min_q)      min_q   <= us_q;
        if (us_q > max_q)      max_q   <= us_q;
        if (count_q != 8'hFF)  count_q <= count_q + 8'd1;
      end
    end
  end

  assign flash        = flash_q;
  assign busy         = (state_q != StIdle);
  assign result_valid = (state_q == StReport);
  assign timeout      = timeout_q;
  assign last_us      = last_q;
  assign min_us       = min_q;
  assign max_us       = max_q;
  assign count        = count_q;

endmodule

// File: tb/tb_lag_meter.sv
// Self-checking bench for lag_meter: table of measurement vectors, hand-written
// corner sequences, and randomized samples against a statistics reference model.
module tb_lag_meter;

  localparam int unsigned UsDiv     = 4;
  localparam int unsigned TimeoutUs = 100;
  localparam int unsigned Debounce  = 4;
  localparam int          MinReset  = 32'h3FFFF;

  logic        clk;
  logic        reset_n;
  logic        vsync;
  logic        arm;
  logic        clear;
  logic        sensor_in;
  logic        flash;
  logic        busy;
  logic        result_valid;
  logic        timeout;
  logic [17:0] last_us;
  logic [17:0] min_us;
  logic [17:0] max_us;
  logic [7:0]  count;

  lag_meter #(
    .US_DIV           (UsDiv),
    .TIMEOUT_US       (TimeoutUs),
    .DEBOUNCE         (Debounce),
    .SENSOR_ACTIVE_LOW(1'b1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .vsync       (vsync),
    .arm         (arm),
    .clear       (clear),
    .sensor_in   (sensor_in),
    .flash       (flash),
    .busy        (busy),
    .result_valid(result_valid),
    .timeout     (timeout),
    .last_us     (last_us),
    .min_us      (min_us),
    .max_us      (max_us),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Observations from the most recent run_meas call.
  int obs_rv_cycle, obs_rv_count, obs_to_cycle, obs_to_count;
  logic obs_flash_c0, obs_flash_c1, obs_flash_vs2, obs_flash_vs2p1;
  logic obs_busy_ab, obs_flash_ab;

  typedef struct {
    int s;
    int vs2;
    bit clr;
    int e_last;
    int e_min;
    int e_max;
    int e_cnt;
  } vec_t;

  vec_t tbl[4];
  int   model_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle c is the interval after posedge c; c=0 is the cycle vsync is first seen high.
  task automatic run_meas(input int on1, input int off1, input int on2, input int off2,
                          input int vs2, input int arm_off, input int clr_at, input int ncyc);
    obs_rv_cycle = -1; obs_rv_count = 0;
    obs_to_cycle = -1; obs_to_count = 0;
    obs_flash_vs2 = 1'bx; obs_flash_vs2p1 = 1'bx;
    for (int c = 0; c < ncyc; c++) begin
      vsync     = (c == 0) || (c == vs2);
      sensor_in = !((c >= on1 && c < off1) || (c >= on2 && c < off2));
      arm       = (arm_off < 0) ? 1'b1 : (c < arm_off);
      clear     = (c == clr_at);
      if (result_valid === 1'b1) begin
        obs_rv_count++;
        if (obs_rv_cycle < 0) obs_rv_cycle = c;
      end
      if (timeout === 1'b1) begin
        obs_to_count++;
        if (obs_to_cycle < 0) obs_to_cycle = c;
      end
      if (c == 0) obs_flash_c0 = flash;
      if (c == 1) obs_flash_c1 = flash;
      if (c == vs2) obs_flash_vs2 = flash;
      if (c == vs2 + 1) obs_flash_vs2p1 = flash;
      if (c == arm_off + 2) begin
        obs_busy_ab  = busy;
        obs_flash_ab = flash;
      end
      tick();
    end
    vsync = 1'b0;
    clear = 1'b0;
  endtask

  // Release the sensor and supply the two vsync edges the cooldown waits for.
  task automatic cooldown();
    sensor_in = 1'b1;
    clear     = 1'b0;
    vsync     = 1'b0;
    repeat (10) tick();
    repeat (2) begin
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      tick();
    end
    repeat (2) tick();
  endtask

  // Expected sample from the timing rule: filtered active at D = s + 2 + DEBOUNCE.
  task automatic check_sample(input string tag, input int s, input int vs2);
    int d;
    d = s + 2 + Debounce;
    check({tag, " rv_count"}, obs_rv_count, 1);
    check({tag, " rv_cycle"}, obs_rv_cycle, d + 1);
    check({tag, " last_us"}, last_us, d / UsDiv);
    check({tag, " flash_c0"}, obs_flash_c0, 0);
    check({tag, " flash_c1"}, obs_flash_c1, 1);
    if (vs2 >= 0) begin
      check({tag, " flash_at_vs2"}, obs_flash_vs2, 1);
      check({tag, " flash_after_vs2"}, obs_flash_vs2p1, 0);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " flash"}, flash, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " result_valid"}, result_valid, 0);
    check({tag, " timeout"}, timeout, 0);
    check({tag, " count"}, count, 0);
    check({tag, " last_us"}, last_us, 0);
    check({tag, " min_us"}, min_us, MinReset);
    check({tag, " max_us"}, max_us, 0);
  endtask

  initial begin
    int d;
    int vs2;
    int s;
    int nflash;
    int e_min;
    int e_max;
    int e_cnt;

    tbl[0] = '{s: 98,  vs2: -1, clr: 1'b0, e_last: 26, e_min: 26,       e_max: 26, e_cnt: 1};
    tbl[1] = '{s: 34,  vs2: 20, clr: 1'b0, e_last: 10, e_min: 10,       e_max: 26, e_cnt: 2};
    tbl[2] = '{s: 154, vs2: -1, clr: 1'b0, e_last: 40, e_min: 10,       e_max: 40, e_cnt: 3};
    tbl[3] = '{s: 14,  vs2: -1, clr: 1'b1, e_last: 5,  e_min: MinReset, e_max: 0,  e_cnt: 0};

    reset_n   = 1'b0;
    vsync     = 1'b0;
    arm       = 1'b0;
    clear     = 1'b0;
    sensor_in = 1'b1;
    repeat (3) tick();
    check_reset("reset");
    reset_n = 1'b1;
    arm     = 1'b1;
    repeat (3) tick();

    // Basic sample and statistics, with a clear landing on the fourth REPORT.
    foreach (tbl[i]) begin
      d = tbl[i].s + 2 + Debounce;
      run_meas(tbl[i].s, 100000, -1, -1, tbl[i].vs2, -1, tbl[i].clr ? d + 1 : -1, d + 4);
      check_sample($sformatf("row%0d", i), tbl[i].s, tbl[i].vs2);
      check($sformatf("row%0d last_us_tbl", i), last_us, tbl[i].e_last);
      check($sformatf("row%0d min_us", i), min_us, tbl[i].e_min);
      check($sformatf("row%0d max_us", i), max_us, tbl[i].e_max);
      check($sformatf("row%0d count", i), count, tbl[i].e_cnt);
      cooldown();
    end

    // Timeout: us_cnt reaches 100 at cycle 400, pulse lands in cycle 401.
    run_meas(-1, -1, -1, -1, -1, -1, -1, 410);
    check("timeout flash_c1", obs_flash_c1, 1);
    check("timeout to_count", obs_to_count, 1);
    check("timeout to_cycle", obs_to_cycle, TimeoutUs * UsDiv + 1);
    check("timeout rv_count", obs_rv_count, 0);
    check("timeout count", count, 0);
    check("timeout min_us", min_us, MinReset);
    check("timeout flash_after", flash, 0);
    check("timeout busy", busy, 1);
    cooldown();

    // Glitch rejection: 3-cycle pulse ignored, later 10-cycle pulse measured.
    run_meas(10, 13, 120, 130, -1, -1, -1, 120 + 2 + Debounce + 4);
    check_sample("glitch", 120, -1);
    check("glitch count", count, 1);
    cooldown();

    // Abort by dropping arm mid-MEASURE.
    run_meas(60, 100000, -1, -1, -1, 50, -1, 80);
    check("abort flash_c1", obs_flash_c1, 1);
    check("abort busy", obs_busy_ab, 0);
    check("abort flash", obs_flash_ab, 0);
    check("abort rv_count", obs_rv_count, 0);
    check("abort count", count, 1);
    sensor_in = 1'b1;
    repeat (10) tick();
    arm = 1'b1;
    repeat (3) tick();

    // Async reset mid-MEASURE: outputs return without a clock edge.
    run_meas(-1, -1, -1, -1, -1, -1, -1, 50);
    check("prereset flash", flash, 1);
    check("prereset busy", busy, 1);
    reset_n   = 1'b0;
    sensor_in = 1'b0;
    arm       = 1'b0;
    #2;
    check_reset("midreset");
    repeat (2) tick();
    reset_n = 1'b1;

    // Stuck sensor: active before arming, WAIT_VS must hold and flash stay low.
    repeat (12) tick();
    arm    = 1'b1;
    nflash = 0;
    repeat (3) begin
      vsync = 1'b1;
      tick();
      if (flash !== 1'b0) nflash++;
      vsync = 1'b0;
      repeat (4) begin
        tick();
        if (flash !== 1'b0) nflash++;
      end
    end
    check("stuck flash_highs", nflash, 0);
    check("stuck busy", busy, 1);
    check("stuck count", count, 0);
    sensor_in = 1'b1;
    repeat (10) tick();
    run_meas(98, 100000, -1, -1, -1, -1, -1, 98 + 2 + Debounce + 4);
    check_sample("stuck_release", 98, -1);
    check("stuck_release count", count, 1);
    cooldown();

    // Randomized samples against a queue-based statistics model.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    model_q.delete();
    for (int k = 0; k < 20; k++) begin
      s   = int'($urandom_range(380, 0));
      d   = s + 2 + Debounce;
      vs2 = int'($urandom_range(d - 1, 2));
      run_meas(s, 100000, -1, -1, vs2, -1, -1, d + 4);
      check_sample($sformatf("rand%0d", k), s, vs2);
      model_q.push_back(d / UsDiv);
      e_min = MinReset;
      e_max = 0;
      foreach (model_q[j]) begin
        if (model_q[j] < e_min) e_min = model_q[j];
        if (model_q[j] > e_max) e_max = model_q[j];
      end
      e_cnt = (model_q.size() > 255) ? 255 : model_q.size();
      check($sformatf("rand%0d min_us", k), min_us, e_min);
      check($sformatf("rand%0d max_us", k), max_us, e_max);
      check($sformatf("rand%0d count", k), count, e_cnt);
      cooldown();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lag_meter.md
# lag_meter

Measures end-to-end display latency for the lag tester. It sits inside the system block, downstream of the video timing generator and the user-port input. It requests a one-frame white flash from the renderer on a VSync edge, then times how long the photo-sensor on the user port takes to see that flash. It reports the result in microseconds, together with running minimum, maximum and sample count for the on-screen readout.

## Interface
Parameters:
- US_DIV, 50: clk cycles per microsecond; must be ≥2.
- TIMEOUT_US, 200000: measurement abandoned at this count; must be < 2^18.
- DEBOUNCE, 16: cycles a synchronized sensor level must be stable to be accepted; must be ≥1.
- SENSOR_ACTIVE_LOW, 1: 1 means the sensor pulls the open-drain line low on light.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- vsync  in  1  VSync from video timing, active high, synchronous to clk.
- arm  in  1  level; 1 enables repeated measurements.
- clear  in  1  one-cycle pulse; clears statistics.
- sensor_in  in  1  raw asynchronous sensor line (USER_IN bit).
- flash  out  1  renderer draws the full-screen flash while high.
- busy  out  1  high in any state except IDLE.
- result_valid  out  1  one-cycle pulse when a new sample lands.
- timeout  out  1  one-cycle pulse when a measurement hits TIMEOUT_US.
- last_us  out  18  most recent valid sample.
- min_us  out  18  smallest sample since clear.
- max_us  out  18  largest sample since clear.
- count  out  8  number of samples since clear; saturates at 255.

## Operation
- Sensor path: 2-flop synchronizer, polarity-normalised to active-high, then a debouncer. The filtered level changes only after the synchronized level differs from it for DEBOUNCE consecutive cycles.
- FSM states: IDLE, WAIT_VS, MEASURE, REPORT, COOLDOWN.
- IDLE → WAIT_VS when arm=1.
- WAIT_VS → MEASURE on a vsync rising edge, provided the filtered sensor is inactive. On entry:
  - prescaler := 0 and us_cnt := 0;
  - flash := 1.
- MEASURE:
  - Prescaler counts 0..US_DIV-1. us_cnt increments on each wrap.
  - flash drops at the next vsync rising edge, so it is high for exactly one frame.
  - Exit to REPORT when the filtered sensor becomes active.
  - Exit to COOLDOWN when us_cnt reaches TIMEOUT_US: pulse timeout and leave the statistics unchanged.
- REPORT (1 cycle):
  - last_us := us_cnt.
  - min_us := min(min_us, us_cnt) and max_us := max(max_us, us_cnt).
  - count := count+1, saturating at 255.
  - Pulse result_valid. Go to COOLDOWN.
- COOLDOWN: flash=0. Wait until the filtered sensor is inactive, then wait 2 further vsync rising edges. Then go to WAIT_VS if arm=1, otherwise IDLE.
- A WAIT_VS entry with the filtered sensor active is held in WAIT_VS until the sensor goes inactive. A stuck sensor therefore produces no false samples.
- arm=0 in any state other than IDLE: go to IDLE on the next cycle. flash drops and no result is produced. An abort during REPORT still completes REPORT first.
- clear: min_us := 0x3FFFF, max_us := 0, count := 0. last_us is not touched.
- clear in the same cycle as REPORT: clear wins for the statistics, so that sample is dropped from min/max/count. last_us and result_valid still update.
- Arithmetic is unsigned 18-bit. us_cnt cannot pass TIMEOUT_US.

## Timing
- Reset values:
  - flash, busy, result_valid, timeout, count = 0;
  - last_us = 0, min_us = 0x3FFFF, max_us = 0;
  - FSM in IDLE; synchronizer and filtered level at inactive.
- Async reset mid-measurement returns all outputs to reset values immediately. No result is emitted.
- vsync edge detection uses a registered previous value. The "start cycle" (cycle 0) is the cycle in which vsync is first sampled 1.
- flash rises in cycle 1, registered. It falls the cycle after the next vsync rising edge is detected.
- The filtered sensor goes active exactly 2+DEBOUNCE cycles after raw sensor_in reaches its active level and stays there.
- Define D as the cycle at which the FSM sees the filtered sensor active, counted from the start cycle. Then result = floor(D/US_DIV).
- result_valid is high in cycle D+1. last_us, min_us, max_us and count are valid from cycle D+2.
- The timeout pulse occurs in the cycle after us_cnt reaches TIMEOUT_US.

## Test plan
- Basic sample: US_DIV=4, DEBOUNCE=4, arm=1, vsync edge at cycle 0, sensor_in active from cycle 98. Required: D=104, last_us=26, min_us=max_us=26, count=1, one result_valid pulse.
- Timeout: TIMEOUT_US=100, sensor never active. Required: timeout pulse after 400 cycles of MEASURE, count stays 0, min_us stays 0x3FFFF. The FSM then continues to WAIT_VS after 2 vsync edges.
- Glitch rejection: a 3-cycle active pulse on sensor_in with DEBOUNCE=4 produces no result. A later 10-cycle pulse produces a result.
- Statistics: samples 26, 10, 40. Required: min_us=10, max_us=40, count=3, last_us=40. A clear coincident with a 4th REPORT (value 5) gives count=0, min_us=0x3FFFF, last_us=5.
- Abort and reset: drop arm mid-MEASURE → flash=0 and busy=0 within 2 cycles, no result_valid. Assert reset_n=0 mid-MEASURE → all outputs at reset values without a clock edge.
- Stuck sensor: sensor held active before arm → the FSM stays in WAIT_VS and flash never rises. After the sensor is released, measurement proceeds normally.
